trade_z_seq: RTL and testbench

- Parametrised, multi-cycle successor of the combinational Z-score trade-signal block.
- Computes z = |sample - mean| * 2^FRAC_W / floor(sqrt(sqr_mean - mean^2)) with an iterative square root and an iterative divider. No library sqrt or "/" operators.
- Adds a valid/ready input handshake, a result valid strobe, a z_score output, and a post-signal cooldown.
- Sits between the rolling-statistics stage and the TLU.

---
 rtl/trade_z_seq.sv | 170 +++++++++++++++++
 tb/tb_trade_z_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/trade_z_seq.sv
// Multi-cycle Z-score trade signal: iterative sqrt of the variance, then a restoring
// divide of |sample - mean| << FRAC_W by the stddev, with a post-signal cooldown.
module trade_z_seq #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned FRAC_W       = 8,
   parameter int unsigned Z_THRESHOLD  = 100,
   parameter int unsigned HOLD_RESULTS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          mean,
   input  logic [DATA_W-1:0]          sample,
   input  logic [2*DATA_W-1:0]        sqr_mean,
   output logic                       out_valid,
   output logic [DATA_W+FRAC_W-1:0]   z_score,
   output logic                       buy_signal,
   output logic                       sell_signal
);

   localparam int unsigned Z_W    = DATA_W + FRAC_W;
   localparam int unsigned CNT_W  = $clog2(Z_W + 1);
   localparam int unsigned COOL_W = (HOLD_RESULTS > 0) ? $clog2(HOLD_RESULTS + 1) : 1;

   typedef enum logic [1:0] {StIdle, StSqrt, StDiv, StDone} state_e;

   state_e              state_q, state_d;
   logic                rdy_q;
   logic [DATA_W-1:0]   mean_q, mean_d, sample_q, sample_d;
   logic [DATA_W-1:0]   root_q, root_d, rem_q, rem_d, drem_q, drem_d;
   logic [2*DATA_W-1:0] rad_q, rad_d, sq;
   logic [Z_W-1:0]      dq_q, dq_d, z_q, z_d, quot, z_new;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [COOL_W-1:0]   cool_q, cool_d;
   logic                ov_q, ov_d, buy_q, buy_d, sell_q, sell_d;

   logic [DATA_W+1:0]   r_shift, r_trial;
   logic                r_ge;
   logic [DATA_W:0]     d_shift;
   logic                d_ge;
   logic [DATA_W-1:0]   diff;
   logic                hit;

   assign sq = {{DATA_W{1'b0}}, mean} * {{DATA_W{1'b0}}, mean};

   // Sqrt step: remainder stays below 2^DATA_W until the final step, whose remainder is dropped.
   assign r_shift = {rem_q, rad_q[2*DATA_W-1 -: 2]};
   assign r_trial = {root_q, 2'b01};
   assign r_ge    = r_shift >= r_trial;

   assign d_shift = {drem_q, dq_q[Z_W-1]};
   assign d_ge    = d_shift >= {1'b0, root_q};
   assign quot    = {dq_q[Z_W-2:0], d_ge};
   assign z_new   = (root_q == '0) ? '0 : quot;
   assign hit     = z_new > Z_W'(Z_THRESHOLD);

   assign diff     = (sample_q > mean_q) ? sample_q - mean_q : mean_q - sample_q;
   assign in_ready = (state_q == StIdle) && rdy_q;

   always_comb begin
      state_d  = state_q;
      mean_d   = mean_q;
      sample_d = sample_q;
      root_d   = root_q;
      rem_d    = rem_q;
      rad_d    = rad_q;
      drem_d   = drem_q;
      dq_d     = dq_q;
      cnt_d    = cnt_q;
      cool_d   = cool_q;
      z_d      = z_q;
      ov_d     = ov_q;
      buy_d    = buy_q;
      sell_d   = sell_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid && in_ready) begin
               mean_d   = mean;
               sample_d = sample;
               rad_d    = (sqr_mean < sq) ? '0 : sqr_mean - sq;
               rem_d    = '0;
               root_d   = '0;
               cnt_d    = '0;
               state_d  = StSqrt;
            end
         end
         StSqrt: begin
            rem_d  = r_ge ? DATA_W'(r_shift - r_trial) : r_shift[DATA_W-1:0];
            root_d = {root_q[DATA_W-2:0], r_ge};
            rad_d  = {rad_q[2*DATA_W-3:0], 2'b00};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               cnt_d   = '0;
               drem_d  = '0;
               dq_d    = {diff, {FRAC_W{1'b0}}};
               state_d = StDiv;
            end
         end
         StDiv: begin
            drem_d = d_ge ? DATA_W'(d_shift - {1'b0, root_q}) : d_shift[DATA_W-1:0];
            dq_d   = quot;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(Z_W - 1)) begin
               state_d = StDone;
               ov_d    = 1'b1;
               z_d     = z_new;
               if (cool_q != '0) begin
                  buy_d  = 1'b0;
                  sell_d = 1'b0;
                  cool_d = cool_q - COOL_W'(1);
               end else begin
                  buy_d  = hit && (sample_q < mean_q);
                  sell_d = hit && (sample_q > mean_q);
                  if (hit && (sample_q != mean_q)) cool_d = COOL_W'(HOLD_RESULTS);
               end
            end
         end
         StDone: begin
            ov_d    = 1'b0;
            buy_d   = 1'b0;
            sell_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         rdy_q    <= 1'b0;
         mean_q   <= '0;
         sample_q <= '0;
         root_q   <= '0;
         rem_q    <= '0;
         rad_q    <= '0;
         drem_q   <= '0;
         dq_q     <= '0;
         cnt_q    <= '0;
         cool_q   <= '0;
         z_q      <= '0;
         ov_q     <= 1'b0;
         buy_q    <= 1'b0;
         sell_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rdy_q    <= 1'b1;
         mean_q   <= mean_d;
         sample_q <= sample_d;
         root_q   <= root_d;
         rem_q    <= rem_d;
         rad_q    <= rad_d;
         drem_q   <= drem_d;
         dq_q     <= dq_d;
         cnt_q    <= cnt_d;
         cool_q   <= cool_d;
         z_q      <= z_d;
         ov_q     <= ov_d;
         buy_q    <= buy_d;
         sell_q   <= sell_d;
      end
   end

   assign out_valid   = ov_q;
   assign z_score     = z_q;
   assign buy_signal  = buy_q;
   assign sell_signal = sell_q;

endmodule

// File: tb/tb_trade_z_seq.sv
// Bench for trade_z_seq: three parameter variants share stimulus and are checked against
// an arithmetic reference model with a cooldown tracker per variant.
module tb_trade_z_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  mean;
   logic [7:0]  sample;
   logic [15:0] sqr_mean;
   logic        rdy [3];
   logic        ov [3];
   logic [15:0] zs [3];
   logic        buy [3];
   logic        sell [3];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          thr [3]  = '{100, 100, 128};
   int          hold [3] = '{2, 0, 0};
   int          cool [3] = '{0, 0, 0};

   trade_z_seq dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .mean(mean),
      .sample(sample), .sqr_mean(sqr_mean), .out_valid(ov[0]), .z_score(zs[0]),
      .buy_signal(buy[0]), .sell_signal(sell[0])
   );
   trade_z_seq #(.HOLD_RESULTS(0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .mean(mean),
      .sample(sample), .sqr_mean(sqr_mean), .out_valid(ov[1]), .z_score(zs[1]),
      .buy_signal(buy[1]), .sell_signal(sell[1])
   );
   trade_z_seq #(.HOLD_RESULTS(0), .Z_THRESHOLD(128)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .mean(mean),
      .sample(sample), .sqr_mean(sqr_mean), .out_valid(ov[2]), .z_score(zs[2]),
      .buy_signal(buy[2]), .sell_signal(sell[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, required finish before time limit");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", tag, got, exp);
      end
   endtask

   function automatic int z_ref(input int m, input int s, input int sq);
      int v, sd, d;
      v = sq - m * m;
      if (v < 0) v = 0;
      sd = 0;
      while ((sd + 1) * (sd + 1) <= v) sd++;
      d = (s > m) ? s - m : m - s;
      return (sd == 0) ? 0 : (d * 256) / sd;
   endfunction

   task automatic check_result(input int m, input int s, input int sq);
      int z;
      bit rb, rs, eb, es;
      z = z_ref(m, s, sq);
      for (int i = 0; i < 3; i++) begin
         rb = (z > thr[i]) && (s < m);
         rs = (z > thr[i]) && (s > m);
         if (cool[i] != 0) begin
            eb = 0;
            es = 0;
            cool[i]--;
         end else begin
            eb = rb;
            es = rs;
            if (rb || rs) cool[i] = hold[i];
         end
         check_eq($sformatf("out_valid[%0d]", i), ov[i], 1);
         check_eq($sformatf("z_score[%0d] m=%0d s=%0d sq=%0d", i, m, s, sq), zs[i], z);
         check_eq($sformatf("buy[%0d] m=%0d s=%0d", i, m, s), buy[i], eb);
         check_eq($sformatf("sell[%0d] m=%0d s=%0d", i, m, s), sell[i], es);
      end
   endtask

   // Called at a negedge while idle; presents one operand set for one cycle.
   task automatic run_op(input int m, input int s, input int sq);
      int lat;
      check_eq("in_ready before op", rdy[0], 1);
      mean     = 8'(m);
      sample   = 8'(s);
      sqr_mean = 16'(sq);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      mean     = 8'($urandom);
      sample   = 8'($urandom);
      sqr_mean = 16'($urandom);
      lat = 1;
      while (ov[0] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_eq("latency", lat, 25);
      if (lat < 40) check_result(m, s, sq);
      @(negedge clk);
      check_eq("out_valid pulse width", ov[0], 0);
      check_eq("buy after done", buy[0], 0);
   endtask

   initial begin
      bit seen;
      bit pend;
      int pcyc, pm, ps, psq, m, t;
      bit exp_ov, exp_rdy;

      rst      = 1'b0;
      in_valid = 1'b0;
      mean     = '0;
      sample   = '0;
      sqr_mean = '0;
      repeat (3) @(negedge clk);
      check_eq("reset in_ready", rdy[0], 0);
      check_eq("reset out_valid", ov[0], 0);
      check_eq("reset z_score", zs[0], 0);
      check_eq("reset buy", buy[0], 0);
      check_eq("reset sell", sell[0], 0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("in_ready after release", rdy[0], 1);

      run_op(100, 98, 10016);
      run_op(100, 101, 10016);
      run_op(100, 102, 10016);
      run_op(100, 50, 10000);
      run_op(100, 50, 9000);
      repeat (4) run_op(100, 98, 10016);

      // Abort an operation mid-sqrt.
      mean     = 8'd100;
      sample   = 8'd98;
      sqr_mean = 16'd10016;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("mid reset z_score", zs[0], 0);
      check_eq("mid reset out_valid", ov[0], 0);
      check_eq("mid reset buy", buy[0], 0);
      check_eq("mid reset sell", sell[0], 0);
      check_eq("mid reset in_ready", rdy[0], 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) cool[i] = 0;
      seen = 0;
      @(negedge clk);
      check_eq("in_ready after mid reset", rdy[0], 1);
      for (int i = 0; i < 30; i++) begin
         if (ov[0] === 1'b1) seen = 1;
         @(negedge clk);
      end
      check_eq("aborted op produced out_valid", seen, 0);
      run_op(100, 98, 10016);

      // in_valid held high with fresh operands every cycle.
      pend = 0;
      pcyc = 0;
      pm = 0;
      ps = 0;
      psq = 0;
      for (int cyc = 0; cyc < 104; cyc++) begin
         exp_ov = pend && (cyc == pcyc + 25);
         check_eq($sformatf("stream out_valid c%0d", cyc), ov[0], 32'(exp_ov));
         if (exp_ov) check_result(pm, ps, psq);
         exp_rdy = !pend || (cyc >= pcyc + 26);
         check_eq($sformatf("stream in_ready c%0d", cyc), rdy[0], 32'(exp_rdy));
         mean     = 8'($urandom);
         sample   = 8'($urandom);
         t        = int'(mean) * int'(mean) + int'($urandom_range(0, 900));
         sqr_mean = 16'((t > 65535) ? 65535 : t);
         in_valid = 1'b1;
         if (exp_rdy) begin
            pend = 1;
            pcyc = cyc;
            pm   = int'(mean);
            ps   = int'(sample);
            psq  = int'(sqr_mean);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;

      for (int n = 0; n < 16; n++) begin
         m = int'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) t = int'($urandom_range(0, 65535));
         else t = m * m + int'($urandom_range(0, 900));
         if (t > 65535) t = 65535;
         run_op(m, int'($urandom_range(0, 255)), t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
